// File: rtl/tone_sweep_ctrl.sv
// rtl/tone_sweep_ctrl.sv - two-tone sweep controller
// Steps tone-1 from start to stop every dwell period; tone-2 and amplitudes stay fixed per sweep.
module tone_sweep_ctrl #(
  parameter int DWELL_W = 24,
  parameter int IDX_W   = 8
) (
  input  logic               clk_in,
  input  logic               reset_p,
  input  logic               start,
  input  logic               stop,
  input  logic [15:0]        cfg_fre_start,
  input  logic [15:0]        cfg_fre_stop,
  input  logic [15:0]        cfg_fre_step,
  input  logic [15:0]        cfg_fre2,
  input  logic [2:0]         cfg_amp1,
  input  logic [2:0]         cfg_amp2,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_loop,
  output logic [2:0]         amp_cnt1,
  output logic [2:0]         amp_cnt2,
  output logic [15:0]        fre_cnt1,
  output logic [15:0]        fre_cnt2,
  output logic               busy,
  output logic               done,
  output logic               wrap,
  output logic               cfg_err,
  output logic [IDX_W-1:0]   step_idx
);

  typedef enum logic {IDLE, DWELL} state_t;

  state_t             state;
  logic [15:0]        start_q;
  logic [15:0]        stop_q;
  logic [15:0]        step_q;
  logic               loop_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [16:0]        next_fre;
  logic               cfg_bad;

  // Carry out of the 17-bit sum means the next word would wrap, so it counts as past the end.
  assign next_fre = {1'b0, fre_cnt1} + {1'b0, step_q};
  assign cfg_bad  = (cfg_fre_step == 16'd0) || (cfg_fre_start > cfg_fre_stop);

  always_ff @(posedge clk_in) begin
    if (reset_p) begin
      state     <= IDLE;
      start_q   <= '0;
      stop_q    <= '0;
      step_q    <= '0;
      loop_q    <= 1'b0;
      dwell_q   <= '0;
      dwell_cnt <= '0;
      amp_cnt1  <= '0;
      amp_cnt2  <= '0;
      fre_cnt1  <= '0;
      fre_cnt2  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wrap      <= 1'b0;
      cfg_err   <= 1'b0;
      step_idx  <= '0;
    end else begin
      done    <= 1'b0;
      wrap    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            if (cfg_bad) begin
              cfg_err <= 1'b1;
            end else begin
              start_q   <= cfg_fre_start;
              stop_q    <= cfg_fre_stop;
              step_q    <= cfg_fre_step;
              loop_q    <= cfg_loop;
              dwell_q   <= (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;
              dwell_cnt <= '0;
              fre_cnt1  <= cfg_fre_start;
              fre_cnt2  <= cfg_fre2;
              amp_cnt1  <= cfg_amp1;
              amp_cnt2  <= cfg_amp2;
              step_idx  <= '0;
              busy      <= 1'b1;
              state     <= DWELL;
            end
          end
        end
        DWELL: begin
          if (stop) begin
            dwell_cnt <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (dwell_cnt == dwell_q - DWELL_W'(1)) begin
            dwell_cnt <= '0;
            if (!next_fre[16] && (next_fre[15:0] <= stop_q)) begin
              fre_cnt1 <= next_fre[15:0];
              if (step_idx != '1) step_idx <= step_idx + IDX_W'(1);
            end else if (loop_q) begin
              fre_cnt1 <= start_q;
              step_idx <= '0;
              wrap     <= 1'b1;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end else begin
            dwell_cnt <= dwell_cnt + DWELL_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/tone_sweep_ctrl.md
TONE_SWEEP_CTRL -- requirements
Module: tone_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter DWELL_W, default 24, setting the width of the dwell counter and of cfg_dwell.
REQ-002 The block SHALL have parameter IDX_W, default 8, setting the width of step_idx.
REQ-003 The block SHALL have port clk_in, input, 1 bit: single 50 MHz clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset_p, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: begin a sweep; sampled only in IDLE.
REQ-006 The block SHALL have port stop, input, 1 bit: abort the sweep.
REQ-007 The block SHALL have port cfg_fre_start, input, 16 bits: first tone-1 frequency word.
REQ-008 The block SHALL have port cfg_fre_stop, input, 16 bits: last allowed tone-1 frequency word.
REQ-009 The block SHALL have port cfg_fre_step, input, 16 bits: tone-1 increment per step.
REQ-010 The block SHALL have port cfg_fre2, input, 16 bits: fixed tone-2 frequency word.
REQ-011 The block SHALL have port cfg_amp1, input, 3 bits: tone-1 amplitude.
REQ-012 The block SHALL have port cfg_amp2, input, 3 bits: tone-2 amplitude.
REQ-013 The block SHALL have port cfg_dwell, input, DWELL_W bits: clk_in cycles per frequency.
REQ-014 The block SHALL have port cfg_loop, input, 1 bit: 1 = restart the sweep at the end instead of finishing.
REQ-015 The block SHALL have port amp_cnt1, output, 3 bits: registered tone-1 amplitude to the generator.
REQ-016 The block SHALL have port amp_cnt2, output, 3 bits: registered tone-2 amplitude to the generator.
REQ-017 The block SHALL have port fre_cnt1, output, 16 bits: registered tone-1 frequency word.
REQ-018 The block SHALL have port fre_cnt2, output, 16 bits: registered tone-2 frequency word.
REQ-019 The block SHALL have port busy, output, 1 bit: sweep in progress.
REQ-020 The block SHALL have port done, output, 1 bit: one-cycle pulse when the sweep completes.
REQ-021 The block SHALL have port wrap, output, 1 bit: one-cycle pulse when a looped sweep restarts.
REQ-022 The block SHALL have port cfg_err, output, 1 bit: one-cycle pulse when start is rejected.
REQ-023 The block SHALL have port step_idx, output, IDX_W bits: index of the current frequency step.

Function
REQ-024 The FSM SHALL have two states: IDLE and DWELL.
REQ-025 On start=1 in IDLE with stop=0, the block SHALL validate the configuration: cfg_fre_step==0 or cfg_fre_start>cfg_fre_stop makes it invalid.
REQ-026 Invalid start: next cycle cfg_err=1 for one cycle; state stays IDLE; outputs unchanged.
REQ-027 Valid start in IDLE at cycle T: at T+1 the block SHALL be in DWELL with fre_cnt1=cfg_fre_start, fre_cnt2=cfg_fre2, amp_cnt1=cfg_amp1, amp_cnt2=cfg_amp2, busy=1, step_idx=0, and the dwell counter at 0.
REQ-028 All cfg_* inputs SHALL be captured on the start cycle; later changes SHALL have no effect until the next start.
REQ-029 Effective dwell D SHALL be max(cfg_dwell,1); each frequency SHALL be presented for exactly D cycles.
REQ-030 The dwell counter SHALL increment every cycle in DWELL; at D-1 it SHALL clear and a step SHALL occur.
REQ-031 Step: next = fre_cnt1 + step, computed 17 bits wide; if next <= stop and bit16 == 0, then fre_cnt1=next and step_idx increments, saturating at all-ones.
REQ-032 Step past the end with loop=0: go to IDLE; busy=0; done=1 for one cycle; fre_cnt1/fre_cnt2/amp outputs hold their last values.
REQ-033 Step past the end with loop=1: fre_cnt1=start; step_idx=0; wrap=1 for one cycle; stay in DWELL; done is not asserted.
REQ-034 start while busy SHALL be ignored.
REQ-035 stop=1 in DWELL: next cycle state IDLE, busy=0, dwell counter cleared, and no done or wrap pulse.
REQ-036 stop=1 in DWELL: frequency and amplitude outputs hold their values.
REQ-037 stop has priority over a simultaneous dwell expiry, and over start in IDLE.
REQ-038 done, wrap and cfg_err SHALL never be high in the same cycle.

Reset
REQ-039 reset_p=1 at a clock edge SHALL force IDLE with all outputs 0: amp_cnt1/2=0, fre_cnt1/2=0, busy=0, done=0, wrap=0, cfg_err=0, step_idx=0, and the dwell counter at 0.
REQ-040 Reset SHALL override start and stop, and SHALL take effect mid-sweep with no done pulse.

Verification
REQ-041 Single sweep: start=100, stop=130, step=10, dwell=3, loop=0 -> fre_cnt1 steps 100,110,120,130, each held 3 cycles; busy=1 for 12 cycles; done pulses once; fre_cnt1 stays 130.
REQ-042 Loop and overflow: start=0xFFF0, stop=0xFFFF, step=0x20, dwell=2, loop=1 -> fre_cnt1 stays 0xFFF0 with a wrap pulse every 2 cycles; step_idx stays 0.
REQ-043 Rejected start: step=0 -> cfg_err pulses once, busy stays 0; start=200 with stop=100 -> same response.
REQ-044 Dwell 0: dwell=0, start=5, stop=7, step=1 -> 5,6,7, each held 1 cycle, then done.
REQ-045 Stop priority: stop asserted in the same cycle as a dwell expiry at fre_cnt1=110 -> next cycle busy=0, fre_cnt1=110, no done; a start pulse mid-sweep has no effect.
REQ-046 Reset mid-sweep: reset_p=1 for one cycle in DWELL -> all outputs 0 next cycle and no done pulse.
